// File: rtl/memory_pkg.sv
// Shared types and constants for the memory bank: controller states and the
// encoding of the read/write request flag.
package memory_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

endpackage

// File: rtl/memory_bank_if.sv
// Request/response bus of the memory bank; the requester is the master and
// the bank itself is the slave.
interface memory_bank_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
);

  logic                  valid;
  logic                  ready;
  logic                  rW;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W/8-1:0]   byteEn;
  logic                  clr;
  logic [DATA_W-1:0]     dout;
  logic                  doutValid;
  logic                  addrErr;

  modport master (
    output valid, rW, addr, din, byteEn, clr,
    input  ready, dout, doutValid, addrErr
  );

  modport slave (
    input  valid, rW, addr, din, byteEn, clr,
    output ready, dout, doutValid, addrErr
  );

endinterface

// File: rtl/memory_bank.sv
// Word-addressed register-array memory with byte-lane writes, one-cycle read
// latency, address-range error reporting and a one-word-per-cycle clear sweep.
module memory_bank
  import memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  memory_bank_if.slave   bus
);

  localparam int NB = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clrCnt_q, clrCnt_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                doutValid_q, doutValid_d;
  logic                addrErr_q, addrErr_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                inRange;
  logic                clrDone;
  logic [DATA_W-1:0]   wrWord;

  assign bus.ready     = (state_q == IDLE) && !bus.clr;
  assign bus.dout      = dout_q;
  assign bus.doutValid = doutValid_q;
  assign bus.addrErr   = addrErr_q;

  assign accept  = bus.valid && bus.ready;
  assign inRange = 32'(bus.addr) < 32'(DEPTH);
  assign clrDone = clrCnt_q == ADDR_W'(DEPTH - 1);

  // Merge enabled byte lanes of the incoming data into the addressed word.
  always_comb begin
    wrWord = inRange ? mem[bus.addr] : '0;
    for (int b = 0; b < NB; b++) begin
      if (bus.byteEn[b]) wrWord[8*b +: 8] = bus.din[8*b +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    clrCnt_d    = clrCnt_q;
    dout_d      = dout_q;
    doutValid_d = 1'b0;
    addrErr_d   = 1'b0;
    case (state_q)
      CLEAR: begin
        if (bus.clr) begin
          clrCnt_d = '0;
        end else if (clrDone) begin
          state_d  = IDLE;
          clrCnt_d = '0;
        end else begin
          clrCnt_d = clrCnt_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (bus.clr) begin
          state_d  = CLEAR;
          clrCnt_d = '0;
        end else if (accept) begin
          addrErr_d = !inRange;
          if (bus.rW == RD) begin
            doutValid_d = 1'b1;
            dout_d      = inRange ? mem[bus.addr] : '0;
          end
        end
      end
      default: begin
        state_d  = CLEAR;
        clrCnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clrCnt_q    <= '0;
      dout_q      <= '0;
      doutValid_q <= 1'b0;
      addrErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clrCnt_q    <= clrCnt_d;
      dout_q      <= dout_d;
      doutValid_q <= doutValid_d;
      addrErr_q   <= addrErr_d;
    end
  end

  // The array has no reset; it is zeroed only by the sweep in CLEAR.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clrCnt_q] <= '0;
    end else if (accept && (bus.rW == WR) && inRange) begin
      mem[bus.addr] <= wrWord;
    end
  end

endmodule
